// File: rtl/inst_rom_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_pkg
// Shared definitions for the instruction ROM and its image loader:
//   - chip-enable encodings, the all-zero instruction word and bus widths
//   - default memory depth (words) and its log2
//   - loader FSM state encoding
//   - helper that positions an image byte inside a big-endian word
// -----------------------------------------------------------------------------
package inst_rom_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int          InstBusW     = 32;
  localparam int          InstAddrBusW = 32;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam int InstMemNumDef     = 1024;
  localparam int InstMemNumLog2Def = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Byte position 0 lands in bits 31:24, position 3 in bits 7:0.
  // For a 2-bit position, (3 - pos) equals ~pos, so the shift is {~pos, 3'b000}.
  function automatic logic [31:0] place_byte(input logic [7:0] b,
                                             input logic [1:0] pos);
    logic [4:0] sh;
    sh = {~pos, 3'b000};
    return {24'h00_0000, b} << sh;
  endfunction

endpackage

// File: rtl/inst_rom_assembler.sv
// -----------------------------------------------------------------------------
// inst_rom_assembler
// Packs a stream of image bytes into big-endian 32-bit words.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   clr_i    in   discard any partial word and restart at byte position 0
//   acc_i    in   byte_i is accepted on this edge
//   byte_i   in   image byte
//   last_i   in   byte_i is the final byte of the image
//   word_o   out  word including byte_i; unfilled low positions are zero
//   wr_o     out  word_o is complete on this edge (4th byte or last byte)
//   pos_o    out  byte position the next accepted byte will occupy
// -----------------------------------------------------------------------------
module inst_rom_assembler
  import inst_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        wr_o,
  output logic [1:0]  pos_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q,  sh_d;

  // sh_q only ever holds the bytes received so far, with every position not
  // yet filled left at zero, so OR-ing in the current byte directly yields a
  // zero-padded word when the image ends mid-word.
  assign word_o = sh_q | place_byte(byte_i, cnt_q);
  assign wr_o   = acc_i && (last_i || (cnt_q == 2'd3));
  assign pos_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      sh_d  = 32'h0;
    end else if (acc_i) begin
      if (wr_o) begin
        cnt_d = 2'd0;
        sh_d  = 32'h0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        sh_d  = word_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom
// Instruction memory with a byte-stream image loader. The CPU side reads
// combinationally; the loader side writes whole words as they are assembled.
//
// Parameters:
//   InstMemNum      depth in 32-bit words (power of two)
//   InstMemNumLog2  log2(InstMemNum)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   ce        in   CPU fetch enable
//   addr      in   CPU byte address (bits 1:0 and bits above the depth ignored)
//   inst      out  fetched word; zero when ce is low or a load is running
//   ld_start  in   pulse: start (or restart) an image load at word 0
//   ld_valid  in   ld_byte is valid
//   ld_byte   in   image byte
//   ld_last   in   ld_byte is the final image byte
//   ld_ready  out  loader accepts a byte this cycle
//   busy      out  load in progress
//   ld_done   out  last load finished (sticky until the next start)
//   ld_err    out  last load ran past the memory depth (sticky)
//   ld_words  out  words written by the current or last load
// -----------------------------------------------------------------------------
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int InstMemNum     = InstMemNumDef,
  parameter int InstMemNumLog2 = InstMemNumLog2Def
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [31:0]             addr,
  output logic [31:0]             inst,
  input  logic                    ld_start,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    busy,
  output logic                    ld_done,
  output logic                    ld_err,
  output logic [InstMemNumLog2:0] ld_words
);

  // One extra bit so the count can reach InstMemNum itself.
  localparam logic [InstMemNumLog2:0] MemDepth = (InstMemNumLog2 + 1)'(InstMemNum);

  ld_state_e                state_q, state_d;
  logic [InstMemNumLog2:0]  words_q, words_d;
  logic                     done_q,  done_d;
  logic                     err_q,   err_d;

  logic [31:0]              mem_q [InstMemNum];

  logic                     in_load;
  logic                     accept;
  logic                     full;
  logic                     asm_wr;
  logic [31:0]              asm_word;
  logic [1:0]               asm_pos;
  logic                     mem_we;
  logic [InstMemNumLog2-1:0] wr_idx;
  logic [InstMemNumLog2-1:0] rd_idx;
  logic                     unused_sigs;

  assign in_load = (state_q == ST_LOAD);

  // A start pulse wins over a byte offered in the same cycle.
  assign accept  = ld_valid && in_load && !ld_start;
  assign full    = (words_q == MemDepth);
  assign mem_we  = asm_wr && !full;
  assign wr_idx  = words_q[InstMemNumLog2-1:0];

  inst_rom_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ld_start),
    .acc_i  (accept),
    .byte_i (ld_byte),
    .last_i (ld_last),
    .word_o (asm_word),
    .wr_o   (asm_wr),
    .pos_o  (asm_pos)
  );

  // Loader FSM: next state and sticky status.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    done_d  = done_q;
    err_d   = err_q;
    if (ld_start) begin
      state_d = ST_LOAD;
      words_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (in_load && asm_wr) begin
      if (full) begin
        // Word completed with no room left: drop it and stop the load.
        state_d = ST_DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        words_d = words_q + 1'b1;
        if (ld_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Memory contents survive reset so a partially reloaded image keeps the
  // words already written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= asm_word;
    end
  end

  // Word-aligned read; upper address bits wrap around the array.
  assign rd_idx = addr[InstMemNumLog2+1:2];
  assign inst   = ((ce == ChipEnable) && !in_load) ? mem_q[rd_idx] : ZeroWord;

  assign ld_ready = in_load;
  assign busy     = in_load;
  assign ld_done  = done_q;
  assign ld_err   = err_q;
  assign ld_words = words_q;

  // Address bits outside the word index and the assembler position are
  // deliberately not used here.
  assign unused_sigs = ^{addr[31:InstMemNumLog2+2], addr[1:0], asm_pos};

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

  logic clk;
  logic rst;

  // Instance A: 16-word memory
  logic        ce_a, ld_start_a, ld_valid_a, ld_last_a;
  logic [31:0] addr_a, inst_a;
  logic [7:0]  ld_byte_a;
  logic        ld_ready_a, busy_a, ld_done_a, ld_err_a;
  logic [4:0]  ld_words_a;

  // Instance B: 4-word memory
  logic        ce_b, ld_start_b, ld_valid_b, ld_last_b;
  logic [31:0] addr_b, inst_b;
  logic [7:0]  ld_byte_b;
  logic        ld_ready_b, busy_b, ld_done_b, ld_err_b;
  logic [2:0]  ld_words_b;

  int total;
  int bad;

  inst_rom #(.InstMemNum(16), .InstMemNumLog2(4)) u_dut (
    .clk(clk), .rst(rst), .ce(ce_a), .addr(addr_a), .inst(inst_a),
    .ld_start(ld_start_a), .ld_valid(ld_valid_a), .ld_byte(ld_byte_a),
    .ld_last(ld_last_a), .ld_ready(ld_ready_a), .busy(busy_a),
    .ld_done(ld_done_a), .ld_err(ld_err_a), .ld_words(ld_words_a)
  );

  inst_rom #(.InstMemNum(4), .InstMemNumLog2(2)) u_small (
    .clk(clk), .rst(rst), .ce(ce_b), .addr(addr_b), .inst(inst_b),
    .ld_start(ld_start_b), .ld_valid(ld_valid_b), .ld_byte(ld_byte_b),
    .ld_last(ld_last_b), .ld_ready(ld_ready_b), .busy(busy_b),
    .ld_done(ld_done_b), .ld_err(ld_err_b), .ld_words(ld_words_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b, input logic last);
    ld_valid_a = 1'b1;
    ld_byte_a  = b;
    ld_last_a  = last;
    tick();
    ld_valid_a = 1'b0;
    ld_last_a  = 1'b0;
  endtask

  task automatic start_a();
    ld_start_a = 1'b1;
    tick();
    ld_start_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    ld_valid_b = 1'b1;
    ld_byte_b  = b;
    ld_last_b  = 1'b0;
    tick();
    ld_valid_b = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce_a   = 1'b1;
    addr_a = a;
    #1;
    check(tag, inst_a, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    ce_a = 1'b0; addr_a = 32'h0; ld_start_a = 1'b0; ld_valid_a = 1'b0;
    ld_byte_a = 8'h00; ld_last_a = 1'b0;
    ce_b = 1'b0; addr_b = 32'h0; ld_start_b = 1'b0; ld_valid_b = 1'b0;
    ld_byte_b = 8'h00; ld_last_b = 1'b0;

    // Reset state
    #7;
    check("rst_busy",     {31'h0, busy_a},     32'h0);
    check("rst_ready",    {31'h0, ld_ready_a}, 32'h0);
    check("rst_done",     {31'h0, ld_done_a},  32'h0);
    check("rst_err",      {31'h0, ld_err_a},   32'h0);
    check("rst_words",    {27'h0, ld_words_a}, 32'h0);
    check("rst_inst_ce0", inst_a,              32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Two-word load, then reads including unaligned and wrapped addresses
    start_a();
    check("ld1_busy",  {31'h0, busy_a},     32'h1);
    check("ld1_ready", {31'h0, ld_ready_a}, 32'h1);
    read_a("ld1_inst_while_busy", 32'h0, 32'h0);
    send_a(8'h34, 1'b0); send_a(8'h01, 1'b0); send_a(8'h00, 1'b0); send_a(8'h01, 1'b0);
    check("ld1_words_mid", {27'h0, ld_words_a}, 32'd1);
    send_a(8'h34, 1'b0); send_a(8'h02, 1'b0); send_a(8'h00, 1'b0); send_a(8'h02, 1'b1);
    check("ld1_words", {27'h0, ld_words_a}, 32'd2);
    check("ld1_done",  {31'h0, ld_done_a},  32'h1);
    check("ld1_err",   {31'h0, ld_err_a},   32'h0);
    check("ld1_busy_after", {31'h0, busy_a}, 32'h0);
    read_a("ld1_a0",  32'h0,  32'h3401_0001);
    read_a("ld1_a4",  32'h4,  32'h3402_0002);
    read_a("ld1_a6",  32'h6,  32'h3402_0002);
    read_a("ld1_a44", 32'h44, 32'h3402_0002);
    ce_a = 1'b0;
    #1;
    check("ld1_ce0", inst_a, 32'h0);

    // Five bytes, last on a partial word -> zero padding
    start_a();
    check("ld2_done_cleared", {31'h0, ld_done_a}, 32'h0);
    send_a(8'hAA, 1'b0); send_a(8'hBB, 1'b0); send_a(8'hCC, 1'b0); send_a(8'hDD, 1'b0);
    send_a(8'hEE, 1'b1);
    check("ld2_words", {27'h0, ld_words_a}, 32'd2);
    check("ld2_done",  {31'h0, ld_done_a},  32'h1);
    check("ld2_ready", {31'h0, ld_ready_a}, 32'h0);
    read_a("ld2_a0", 32'h0, 32'hAABB_CCDD);
    read_a("ld2_a4", 32'h4, 32'hEE00_0000);

    // Restart mid-load; byte offered with the start pulse is dropped
    start_a();
    send_a(8'h01, 1'b0); send_a(8'h02, 1'b0); send_a(8'h03, 1'b0);
    send_a(8'h04, 1'b0); send_a(8'h05, 1'b0); send_a(8'h06, 1'b0);
    check("rs_words_pre", {27'h0, ld_words_a}, 32'd1);
    ld_start_a = 1'b1; ld_valid_a = 1'b1; ld_byte_a = 8'h77;
    tick();
    ld_start_a = 1'b0; ld_valid_a = 1'b0;
    check("rs_words_clr", {27'h0, ld_words_a}, 32'd0);
    check("rs_busy",      {31'h0, busy_a},     32'h1);
    send_a(8'h11, 1'b0); send_a(8'h22, 1'b0); send_a(8'h33, 1'b0); send_a(8'h44, 1'b0);
    check("rs_words1", {27'h0, ld_words_a}, 32'd1);
    send_a(8'h55, 1'b0); send_a(8'h66, 1'b0); send_a(8'h77, 1'b0); send_a(8'h88, 1'b1);
    check("rs_words2", {27'h0, ld_words_a}, 32'd2);
    read_a("rs_a0", 32'h0, 32'h1122_3344);
    read_a("rs_a4", 32'h4, 32'h5566_7788);

    // Full 4-word image, then partial reload interrupted by reset
    start_a();
    for (int w = 1; w <= 4; w++)
      for (int k = 0; k < 4; k++)
        send_a(8'(w), (w == 4) && (k == 3));
    check("rl_words4", {27'h0, ld_words_a}, 32'd4);
    start_a();
    for (int w = 1; w <= 3; w++)
      for (int k = 0; k < 4; k++)
        send_a(8'(8'hA0 + w), 1'b0);
    send_a(8'hFF, 1'b0); send_a(8'hFF, 1'b0);
    check("rl_words3", {27'h0, ld_words_a}, 32'd3);
    rst = 1'b0;
    #1;
    check("rl_rst_words", {27'h0, ld_words_a}, 32'd0);
    check("rl_rst_busy",  {31'h0, busy_a},     32'h0);
    check("rl_rst_ready", {31'h0, ld_ready_a}, 32'h0);
    check("rl_rst_done",  {31'h0, ld_done_a},  32'h0);
    read_a("rl_rst_read_ce1", 32'h0, 32'hA1A1_A1A1);
    tick();
    rst = 1'b1;
    tick();
    read_a("rl_a0",  32'h0,  32'hA1A1_A1A1);
    read_a("rl_a8",  32'h8,  32'hA3A3_A3A3);
    read_a("rl_aC",  32'hC,  32'h0404_0404);
    read_a("rl_a40", 32'h40, 32'hA1A1_A1A1);
    read_a("rl_a43", 32'h43, 32'hA1A1_A1A1);
    ce_a = 1'b0;

    // Overflow on the 4-word instance
    ld_start_b = 1'b1;
    tick();
    ld_start_b = 1'b0;
    for (int i = 0; i < 16; i++) send_b(8'(i));
    check("ov_words16", {29'h0, ld_words_b}, 32'd4);
    check("ov_busy16",  {31'h0, busy_b},     32'h1);
    check("ov_err16",   {31'h0, ld_err_b},   32'h0);
    for (int i = 16; i < 20; i++) send_b(8'(i));
    check("ov_err",   {31'h0, ld_err_b},   32'h1);
    check("ov_done",  {31'h0, ld_done_b},  32'h1);
    check("ov_words", {29'h0, ld_words_b}, 32'd4);
    check("ov_ready", {31'h0, ld_ready_b}, 32'h0);
    send_b(8'hEE); send_b(8'hEE); send_b(8'hEE); send_b(8'hEE);
    check("ov_words_after", {29'h0, ld_words_b}, 32'd4);
    ce_b = 1'b1;
    addr_b = 32'h0; #1; check("ov_m0", inst_b, 32'h0001_0203);
    addr_b = 32'h4; #1; check("ov_m1", inst_b, 32'h0405_0607);
    addr_b = 32'h8; #1; check("ov_m2", inst_b, 32'h0809_0A0B);
    addr_b = 32'hC; #1; check("ov_m3", inst_b, 32'h0C0D_0E0F);
    addr_b = 32'h10; #1; check("ov_wrap", inst_b, 32'h0001_0203);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter InstMemNum, default 1024, depth of the instruction memory in 32-bit words (power of two).
REQ-002 SHALL have parameter InstMemNumLog2, default 10, log2(InstMemNum).
REQ-003 SHALL have the ports below; one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- ce  input  1  CPU fetch enable (pipeline rom_ce_o).
- addr  input  32  CPU byte address (pipeline rom_addr_o).
- inst  output  32  fetched instruction word (pipeline rom_data_i).
- ld_start  input  1  one-cycle pulse: begin a new image load at word 0.
- ld_valid  input  1  ld_byte carries a valid byte.
- ld_byte  input  8  image byte.
- ld_last  input  1  qualifies ld_byte as the final image byte.
- ld_ready  output  1  loader accepts a byte this cycle.
- busy  output  1  load in progress; the CPU is held in reset or stalled externally.
- ld_done  output  1  last load finished (sticky).
- ld_err  output  1  last load overflowed memory depth (sticky).
- ld_words  output  InstMemNumLog2+1  words written by the current or last load.

Function
REQ-004 SHALL implement loader FSM states IDLE, LOAD, DONE.
REQ-005 IDLE/DONE -> LOAD on ld_start; entering LOAD clears ld_words, byte counter, partial word, ld_done, ld_err.
REQ-006 ld_start during LOAD SHALL restart: partial word discarded, counters cleared, state remains LOAD; ld_start takes priority over a byte offered in the same cycle.
REQ-007 ld_ready SHALL equal (state==LOAD); a byte is accepted on a rising edge where ld_valid && ld_ready && !ld_start.
REQ-008 Bytes SHALL assemble big-endian: byte 0 -> bits 31:24, byte 1 -> 23:16, byte 2 -> 15:8, byte 3 -> 7:0.
REQ-009 On the edge accepting byte 3, the assembled word SHALL be written to mem[ld_words] and ld_words incremented; no extra cycle.
REQ-010 An accepted byte with ld_last at byte position k<3 SHALL write the word with positions k+1..3 zero-padded and increment ld_words.
REQ-011 An accepted ld_last byte SHALL move LOAD -> DONE with ld_done=1 on the same edge.
REQ-012 A word completing when ld_words==InstMemNum SHALL NOT be written; ld_err=1, ld_done=1, state -> DONE; subsequent bytes ignored.
REQ-013 busy SHALL equal (state==LOAD).
REQ-014 inst SHALL be combinational, zero latency: 0 when ce==0 or busy==1, else mem[addr[InstMemNumLog2+1:2]].
REQ-015 addr[1:0] SHALL be ignored; address bits above InstMemNumLog2+1 SHALL be ignored (wrap-around).
REQ-016 A read of the word being written on the same edge SHALL return the old contents (busy forces 0 regardless).
REQ-017 ld_words width SHALL hold InstMemNum without overflow.

Reset
REQ-018 rst low SHALL asynchronously force: state IDLE, ld_words 0, byte counter 0, partial word 0, ld_done 0, ld_err 0, ld_ready 0, busy 0.
REQ-019 inst SHALL read 0 during reset only when ce==0; memory contents SHALL NOT be reset.
REQ-020 Reset mid-load SHALL discard the partial word; words already written SHALL be retained.

Structure
REQ-021 ChipEnable/ChipDisable, ZeroWord, InstBus, InstAddrBus and InstMemNum/InstMemNumLog2 defaults SHALL reside in the shared defines file.
REQ-022 The byte assembler (counter, shift register, last/pad logic) SHALL be one sub-module, inst_rom_assembler; FSM and memory array stay in inst_rom.

Verification
REQ-023 Load bytes 34 01 00 01, 34 02 00 02 with ld_last on the 8th -> ld_words=2, ld_done=1; ce=1, addr=0x0 -> inst=0x34010001; addr=0x4 -> 0x34020002; addr=0x6 -> 0x34020002.
REQ-024 Load 5 bytes AA BB CC DD EE, ld_last on EE -> mem[1]=0xEE000000, ld_words=2, state DONE.
REQ-025 InstMemNum=4, stream 20 bytes without ld_last -> ld_err=1, ld_done=1, ld_words=4, mem[0..3] hold first 16 bytes, later bytes ignored.
REQ-026 During LOAD, ce=1, addr=0x0 -> inst=0, busy=1; ce=0 at any time -> inst=0.
REQ-027 ld_start pulsed after 6 bytes with ld_valid high same cycle -> byte dropped, ld_words=0; next 4 bytes 11 22 33 44 -> mem[0]=0x11223344.
REQ-028 rst low after 2 bytes of word 3 -> IDLE, ld_words=0, mem[0..2] unchanged, mem[3] unchanged; addr=0x40 with InstMemNum=16 reads mem[0].
